// File: rtl/cp0_exc_sched.sv
// rtl/cp0_exc_sched.sv - CP0 write-port sequencer for exceptions, ERET and MTC0
// Optional macro CP0_BEV_VECTOR_EN: exception vector chosen by the snapshot Status.BEV.
module cp0_exc_sched #(
  parameter logic [31:0] EXC_VECTOR       = 32'hBFC00380,
  parameter logic [31:0] EXC_VECTOR_NOBEV = 32'h80000180,
  parameter int          SYNC_STAGES      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badva,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_waddr,
  input  logic [2:0]  mtc0_wsel,
  input  logic [31:0] mtc0_wdata,
  output logic        mtc0_ready,
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [2:0]  cp0_wsel,
  output logic [31:0] cp0_wdata,
  output logic [5:0]  int_sync,
  output logic        int_pending,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_BADVA  = 3'd1;
  localparam logic [2:0] W_EPC    = 3'd2;
  localparam logic [2:0] W_CAUSE  = 3'd3;
  localparam logic [2:0] W_STATUS = 3'd4;
  localparam logic [2:0] REDIRECT = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic        capture;
  logic        s_exc;
  logic [4:0]  s_code;
  logic [31:0] s_pc;
  logic        s_bd;
  logic [31:0] s_badva;
  logic [31:0] s_status;
  logic [31:7] s_cause;
  logic [31:0] s_epc;
  logic        bd_eff;
  logic        use_bev_vec;
  logic [31:0] exc_target;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic        unused_cause;

  assign capture      = (state == IDLE) && (exc_valid || eret);
  assign busy         = (state != IDLE);
  assign unused_cause = ^cause[6:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (exc_valid) begin
          if (exc_code == 5'd4 || exc_code == 5'd5) state_nx = W_BADVA;
          else if (!status[1])                      state_nx = W_EPC;
          else                                      state_nx = W_CAUSE;
        end else if (eret) begin
          state_nx = W_STATUS;
        end
      end
      W_BADVA:  state_nx = s_status[1] ? W_CAUSE : W_EPC;
      W_EPC:    state_nx = W_CAUSE;
      W_CAUSE:  state_nx = W_STATUS;
      W_STATUS: state_nx = REDIRECT;
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

`ifdef CP0_BEV_VECTOR_EN
  assign use_bev_vec = s_status[22];
`else
  assign use_bev_vec = 1'b1;
`endif
  assign exc_target = use_bev_vec ? EXC_VECTOR : EXC_VECTOR_NOBEV;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      s_exc          <= 1'b0;
      s_code         <= '0;
      s_pc           <= '0;
      s_bd           <= 1'b0;
      s_badva        <= '0;
      s_status       <= '0;
      s_cause        <= '0;
      s_epc          <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_nx;
      flush          <= capture;
      redirect_valid <= (state == W_STATUS);
      if (state == W_STATUS)
        redirect_pc <= s_exc ? exc_target : s_epc;
      if (capture) begin
        s_status <= status;
        if (exc_valid) begin
          s_exc   <= 1'b1;
          s_code  <= exc_code;
          s_pc    <= exc_pc;
          s_bd    <= exc_bd;
          s_badva <= exc_badva;
          s_cause <= cause[31:7];
        end else begin
          s_exc <= 1'b0;
          s_epc <= epc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign int_sync = sync_q[SYNC_STAGES-1];

  // BD in Cause tracks the faulting instruction only when this exception also wrote EPC
  assign bd_eff = s_status[1] ? s_cause[31] : s_bd;

  always_comb begin
    mtc0_ready = (state == IDLE) && !exc_valid && !eret;
    cp0_we     = 1'b0;
    cp0_waddr  = '0;
    cp0_wsel   = '0;
    cp0_wdata  = '0;
    case (state)
      IDLE: begin
        if (mtc0_ready) begin
          cp0_we    = mtc0_we;
          cp0_waddr = mtc0_waddr;
          cp0_wsel  = mtc0_wsel;
          cp0_wdata = mtc0_wdata;
        end
      end
      W_BADVA: begin
        cp0_we    = 1'b1;
        cp0_waddr = 5'd8;
        cp0_wdata = s_badva;
      end
      W_EPC: begin
        cp0_we    = 1'b1;
        cp0_waddr = 5'd14;
        cp0_wdata = s_bd ? (s_pc - 32'd4) : s_pc;
      end
      W_CAUSE: begin
        cp0_we    = 1'b1;
        cp0_waddr = 5'd13;
        cp0_wdata = {bd_eff, s_cause[30:7], s_code, 2'b00};
      end
      W_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = 5'd12;
        cp0_wdata = {s_status[31:2], s_exc, s_status[0]};
      end
      default: ;
    endcase
  end

  assign int_pending = status[0] & ~status[1]
                     & (|({int_sync, cause[9:8]} & status[15:8])) & ~busy;

endmodule

// File: tb/tb_cp0_exc_sched.sv
// tb/tb_cp0_exc_sched.sv - scoreboard bench for cp0_exc_sched
`timescale 1ns/1ps
module tb_cp0_exc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badva;
  logic        eret;
  logic        mtc0_we;
  logic [4:0]  mtc0_waddr;
  logic [2:0]  mtc0_wsel;
  logic [31:0] mtc0_wdata;
  logic        mtc0_ready;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [2:0]  cp0_wsel;
  logic [31:0] cp0_wdata;
  logic [5:0]  int_sync;
  logic        int_pending;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  always #5 clk = ~clk;

  cp0_exc_sched dut (
    .clk(clk), .rst(rst), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva(exc_badva), .eret(eret),
    .mtc0_we(mtc0_we), .mtc0_waddr(mtc0_waddr), .mtc0_wsel(mtc0_wsel),
    .mtc0_wdata(mtc0_wdata), .mtc0_ready(mtc0_ready),
    .status(status), .cause(cause), .epc(epc),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wsel(cp0_wsel), .cp0_wdata(cp0_wdata),
    .int_sync(int_sync), .int_pending(int_pending), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  typedef struct { int cyc; logic [4:0] addr; logic [2:0] sel; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] pc; } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  int  fq[$];
  wr_t me;
  rd_t mr;
  int  mf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_busy = 0;
  bit mon_en = 1'b1;
  logic [31:0] last_rpc = '0;

  logic        d_exc, d_eret, d_bd;
  logic [4:0]  d_code;
  logic [31:0] d_pc, d_badva, d_status, d_cause, d_epc;
  logic        m_pend;
  logic [4:0]  m_addr;
  logic [2:0]  m_sel;
  logic [31:0] m_data;
  logic [4:0]  codes [8] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13};

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: an exception becomes the list of register writes it implies, one per cycle
  task automatic push_exc(input int t, input logic [4:0] code, input logic [31:0] pc,
                          input logic bd, input logic [31:0] badva, input logic [31:0] st,
                          input logic [31:0] cs, output int nb);
    int n = 0;
    logic [31:0] vec;
    logic bde;
    if (code == 5'd4 || code == 5'd5) begin
      wq.push_back('{t + 1 + n, 5'd8, 3'd0, badva}); n++;
    end
    if (!st[1]) begin
      wq.push_back('{t + 1 + n, 5'd14, 3'd0, bd ? pc - 32'd4 : pc}); n++;
    end
    bde = st[1] ? cs[31] : bd;
    wq.push_back('{t + 1 + n, 5'd13, 3'd0,
                   (cs & 32'h7FFF_FF80) | (32'(bde) << 31) | (32'(code) << 2)}); n++;
    wq.push_back('{t + 1 + n, 5'd12, 3'd0, st | 32'h2}); n++;
    vec = 32'hBFC00380;
`ifdef CP0_BEV_VECTOR_EN
    if (!st[22]) vec = 32'h80000180;
`endif
    rq.push_back('{t + 1 + n, vec});
    fq.push_back(t + 1);
    nb = n + 1;
  endtask

  task automatic push_eret(input int t, input logic [31:0] st, input logic [31:0] ep,
                           output int nb);
    wq.push_back('{t + 1, 5'd12, 3'd0, st & ~32'h2});
    rq.push_back('{t + 2, ep});
    fq.push_back(t + 1);
    nb = 2;
  endtask

  task automatic step();
    bit idle, tk_exc, tk_eret, acc;
    int nb;
    logic ip;
    @(negedge clk);
    exc_valid = d_exc; eret = d_eret; exc_code = d_code; exc_pc = d_pc;
    exc_bd = d_bd; exc_badva = d_badva; status = d_status; cause = d_cause; epc = d_epc;
    mtc0_we = m_pend; mtc0_waddr = m_addr; mtc0_wsel = m_sel; mtc0_wdata = m_data;
    idle    = (model_busy == 0);
    tk_exc  = idle && d_exc;
    tk_eret = idle && !d_exc && d_eret;
    acc     = m_pend && idle && !d_exc && !d_eret;
    nb = 0;
    if (tk_exc) push_exc(cyc, d_code, d_pc, d_bd, d_badva, d_status, d_cause, nb);
    else if (tk_eret) push_eret(cyc, d_status, d_epc, nb);
    if (acc) wq.push_back('{cyc, m_addr, m_sel, m_data});
    ip = d_status[0] && !d_status[1] && (|(d_cause[9:8] & d_status[9:8])) && idle;
    #1;
    chk("mtc0_ready", mtc0_ready, idle && !d_exc && !d_eret);
    chk("busy", busy, !idle);
    chk("int_pending", int_pending, ip);
    @(posedge clk);
    if (nb != 0) model_busy = nb;
    else if (model_busy > 0) model_busy--;
    if (acc) m_pend = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    d_exc = 1'b0; d_eret = 1'b0;
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (cp0_we) begin
        if (wq.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          me = wq.pop_front();
          chk("wr_cycle", cyc, me.cyc);
          chk("wr_addr", cp0_waddr, me.addr);
          chk("wr_sel", cp0_wsel, me.sel);
          chk("wr_data", cp0_wdata, me.data);
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) chk("redirect_unexpected", 1, 0);
        else begin
          mr = rq.pop_front();
          chk("rd_cycle", cyc, mr.cyc);
          chk("redirect_pc", redirect_pc, mr.pc);
          last_rpc = mr.pc;
        end
      end else begin
        chk("redirect_pc_hold", redirect_pc, last_rpc);
      end
      if (flush) begin
        if (fq.size() == 0) chk("flush_unexpected", 1, 0);
        else begin
          mf = fq.pop_front();
          chk("flush_cycle", cyc, mf);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; hw_int = '0;
    exc_valid = 0; eret = 0; exc_code = '0; exc_pc = '0; exc_bd = 0; exc_badva = '0;
    mtc0_we = 0; mtc0_waddr = '0; mtc0_wsel = '0; mtc0_wdata = '0;
    status = '0; cause = '0; epc = '0;
    d_exc = 0; d_eret = 0; d_bd = 0; d_code = '0; d_pc = '0; d_badva = '0;
    d_status = '0; d_cause = '0; d_epc = '0;
    m_pend = 0; m_addr = '0; m_sel = '0; m_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cp0_we", cp0_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_int_pending", int_pending, 0);
    chk("rst_mtc0_ready", mtc0_ready, 1);
    chk("rst_flush", flush, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_int_sync", int_sync, 0);
    rst = 1'b0;

    // AdEL with BadVAddr, EPC, Cause, Status and a 5-cycle occupancy
    d_exc = 1; d_code = 5'd4; d_pc = 32'hBFC00100; d_bd = 0; d_badva = 32'h3;
    d_status = 32'h00400000; d_cause = 32'h0;
    step(); idle_steps(7);
    // Delay-slot syscall
    d_exc = 1; d_code = 5'd8; d_pc = 32'h80001004; d_bd = 1; d_status = 32'h00400000;
    d_cause = 32'h0;
    step(); idle_steps(6);
    // Nested exception keeps Cause.BD from the input cause
    d_exc = 1; d_code = 5'd12; d_pc = 32'h80003000; d_bd = 0; d_status = 32'h00400003;
    d_cause = 32'h80000000;
    step(); idle_steps(6);
    // ERET
    d_eret = 1; d_epc = 32'h80002000; d_status = 32'h0000FF03; d_cause = 32'h0;
    step(); idle_steps(4);
    // MTC0 colliding with an exception commit
    m_pend = 1; m_addr = 5'd11; m_sel = 3'd0; m_data = 32'h12345678;
    d_exc = 1; d_code = 5'd8; d_pc = 32'h80000100; d_bd = 0; d_status = 32'h0; d_cause = 32'h0;
    step();
    d_exc = 0;
    for (int i = 0; i < 20 && m_pend; i++) step();
    chk("collision_accept", m_pend, 0);
    idle_steps(2);

    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (model_busy == 0) begin
        d_exc  = (r < 3);
        d_eret = (r == 0) || (r == 3) || (r == 4);
      end else begin
        d_exc  = ($urandom_range(0, 3) == 0);
        d_eret = ($urandom_range(0, 3) == 0);
      end
      d_code = codes[$urandom_range(0, 7)];
      d_pc = $urandom; d_bd = 1'($urandom_range(0, 1)); d_badva = $urandom;
      d_status = $urandom; d_cause = $urandom; d_epc = $urandom;
      if (!m_pend && $urandom_range(0, 3) == 0) begin
        m_pend = 1; m_addr = 5'($urandom); m_sel = 3'($urandom); m_data = $urandom;
      end
      step();
    end
    d_exc = 0; d_eret = 0;
    for (int i = 0; i < 30 && (model_busy != 0 || m_pend); i++) step();
    idle_steps(1);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("fq_drained", fq.size(), 0);

    // Interrupt synchroniser and pending flag
    @(negedge clk);
    exc_valid = 0; eret = 0; mtc0_we = 0; status = 32'h401; cause = 32'h0; hw_int = 6'h01;
    #1 chk("int_pending_pre", int_pending, 0);
    @(negedge clk); #1 chk("int_pending_stage1", int_pending, 0);
    @(negedge clk); #1 chk("int_pending_set", int_pending, 1);
    chk("int_sync_set", int_sync, 6'h01);
    status = 32'h403;
    #1 chk("int_pending_exl", int_pending, 0);

    // Asynchronous reset in the middle of W_EPC
    mon_en = 1'b0;
    @(negedge clk);
    hw_int = '0; status = 32'h0; exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h80000200; exc_bd = 0;
    @(negedge clk);
    exc_valid = 0;
    #1;
    chk("pre_rst_we", cp0_we, 1);
    chk("pre_rst_addr", cp0_waddr, 14);
    chk("pre_rst_flush", flush, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_we", cp0_we, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_flush", flush, 0);
    chk("async_rst_redirect_valid", redirect_valid, 0);
    chk("async_rst_redirect_pc", redirect_pc, 0);
    chk("async_rst_int_sync", int_sync, 0);
    chk("async_rst_mtc0_ready", mtc0_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      chk("post_rst_we", cp0_we, 0);
      chk("post_rst_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
